// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the multi-cycle RV32I control path.
// Holds the sequencer states, the datapath select encodings and the decoder vocabulary.
package risc_v_mike_pkg;

  localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, MEM, WB, TRAP, HALT
  } t_seq_state;

  typedef enum logic [1:0] {
    PC_PLUS4, PC_TARGET, PC_JALR, PC_TRAP
  } t_pc_sel;

  typedef enum logic [1:0] {
    WB_ALU, WB_MEM, WB_PC4, WB_IMM
  } t_wb_sel;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_ALU, CLS_LUI, CLS_AUIPC, CLS_LOAD, CLS_STORE,
    CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_SYSTEM
  } t_op_class;

  typedef enum logic [5:0] {
    OP_NA,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_ECALL, OP_EBREAK
  } t_instr_nmemonic;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  function automatic logic is_mem_class(input t_op_class cls);
    return (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

endpackage

// File: rtl/risc_v_instr_decode.sv
// Combinational RV32I decoder: instruction word -> mnemonic and opcode class.
// Kept free of state so the pipelined core can reuse it unchanged.
module risc_v_instr_decode
  import risc_v_mike_pkg::*;
(
  input  logic [31:0]     i_instr,
  output t_instr_nmemonic o_op,
  output t_op_class       o_cls
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  t_instr_nmemonic w_op;
  t_op_class       w_cls;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];

  // Any encoding not matched below stays OP_NA, which the sequencer treats as illegal.
  always_comb begin
    w_op  = OP_NA;
    w_cls = CLS_NONE;
    case (w_opcode)
      OPC_LUI:   begin w_op = OP_LUI;   w_cls = CLS_LUI;   end
      OPC_AUIPC: begin w_op = OP_AUIPC; w_cls = CLS_AUIPC; end
      OPC_JAL:   begin w_op = OP_JAL;   w_cls = CLS_JAL;   end
      OPC_JALR: begin
        w_cls = CLS_JALR;
        if (w_funct3 == 3'b000) w_op = OP_JALR;
      end
      OPC_BRANCH: begin
        w_cls = CLS_BRANCH;
        case (w_funct3)
          3'b000:  w_op = OP_BEQ;
          3'b001:  w_op = OP_BNE;
          3'b100:  w_op = OP_BLT;
          3'b101:  w_op = OP_BGE;
          3'b110:  w_op = OP_BLTU;
          3'b111:  w_op = OP_BGEU;
          default: w_op = OP_NA;
        endcase
      end
      OPC_LOAD: begin
        w_cls = CLS_LOAD;
        case (w_funct3)
          3'b000:  w_op = OP_LB;
          3'b001:  w_op = OP_LH;
          3'b010:  w_op = OP_LW;
          3'b100:  w_op = OP_LBU;
          3'b101:  w_op = OP_LHU;
          default: w_op = OP_NA;
        endcase
      end
      OPC_STORE: begin
        w_cls = CLS_STORE;
        case (w_funct3)
          3'b000:  w_op = OP_SB;
          3'b001:  w_op = OP_SH;
          3'b010:  w_op = OP_SW;
          default: w_op = OP_NA;
        endcase
      end
      OPC_OPIMM: begin
        w_cls = CLS_ALU;
        case (w_funct3)
          3'b000:  w_op = OP_ADDI;
          3'b010:  w_op = OP_SLTI;
          3'b011:  w_op = OP_SLTIU;
          3'b100:  w_op = OP_XORI;
          3'b110:  w_op = OP_ORI;
          3'b111:  w_op = OP_ANDI;
          3'b001:  if (w_funct7 == F7_BASE) w_op = OP_SLLI;
          3'b101: begin
            if (w_funct7 == F7_BASE)     w_op = OP_SRLI;
            else if (w_funct7 == F7_ALT) w_op = OP_SRAI;
          end
          default: w_op = OP_NA;
        endcase
      end
      OPC_OP: begin
        w_cls = CLS_ALU;
        case ({w_funct7, w_funct3})
          {F7_BASE, 3'b000}: w_op = OP_ADD;
          {F7_ALT,  3'b000}: w_op = OP_SUB;
          {F7_BASE, 3'b001}: w_op = OP_SLL;
          {F7_BASE, 3'b010}: w_op = OP_SLT;
          {F7_BASE, 3'b011}: w_op = OP_SLTU;
          {F7_BASE, 3'b100}: w_op = OP_XOR;
          {F7_BASE, 3'b101}: w_op = OP_SRL;
          {F7_ALT,  3'b101}: w_op = OP_SRA;
          {F7_BASE, 3'b110}: w_op = OP_OR;
          {F7_BASE, 3'b111}: w_op = OP_AND;
          default:           w_op = OP_NA;
        endcase
      end
      // FENCE is a no-op on this in-order core; it flows like an ALU op with rd=x0.
      OPC_FENCE: begin
        w_cls = CLS_ALU;
        if (w_funct3 == 3'b000) w_op = OP_FENCE;
      end
      OPC_SYSTEM: begin
        w_cls = CLS_SYSTEM;
        if (i_instr == INSTR_ECALL)       w_op = OP_ECALL;
        else if (i_instr == INSTR_EBREAK) w_op = OP_EBREAK;
      end
      default: begin
        w_op  = OP_NA;
        w_cls = CLS_NONE;
      end
    endcase
    if (w_op == OP_NA) w_cls = CLS_NONE;
  end

  assign o_op  = w_op;
  assign o_cls = w_cls;

endmodule

// File: rtl/risc_v_mc_sequencer.sv
// Multi-cycle RV32I control sequencer (FETCH/DECODE/EXECUTE/MEM/WB/TRAP/HALT).
// Optional perf counters and their ports are built when RISCV_SEQ_PERF_CNT_EN is defined.
module risc_v_mc_sequencer
  import risc_v_mike_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_i,
  output logic            imem_req_o,
  input  logic            imem_ack_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  input  logic            dmem_ack_i,
  input  logic            br_taken_i,
  output logic            ir_we_o,
  output logic            pc_we_o,
  output t_pc_sel         pc_sel_o,
  output logic            rf_we_o,
  output t_wb_sel         wb_sel_o,
  output t_instr_nmemonic alu_op_o,
  output logic            retire_o,
  output logic            trap_o,
  output logic            halt_o
`ifdef RISCV_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]     cycle_cnt_o,
  output logic [31:0]     instret_cnt_o
`endif
);

  // The datapath applies TRAP_VEC itself; only its alignment matters here.
  if (TRAP_VEC[1:0] != 2'b00) begin : g_badTrapVec
    $error("TRAP_VEC must be word aligned");
  end

  t_seq_state      r_state;
  t_instr_nmemonic r_aluOp;
  t_op_class       r_cls;
  t_instr_nmemonic w_decOp;
  t_op_class       w_decCls;

  risc_v_instr_decode u_decode (
    .i_instr (instr_i),
    .o_op    (w_decOp),
    .o_cls   (w_decCls)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
      r_aluOp <= OP_NA;
      r_cls   <= CLS_NONE;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ack_i) r_state <= DECODE;
        end
        DECODE: begin
          r_aluOp <= w_decOp;
          r_cls   <= w_decCls;
          if ((w_decOp == OP_NA) || (w_decOp == OP_EBREAK)) r_state <= HALT;
          else if (w_decOp == OP_ECALL)                      r_state <= TRAP;
          else                                               r_state <= EXECUTE;
        end
        EXECUTE: begin
          if (r_cls == CLS_BRANCH)     r_state <= FETCH;
          else if (is_mem_class(r_cls)) r_state <= MEM;
          else                         r_state <= WB;
        end
        MEM: begin
          if (dmem_ack_i) begin
            if (r_cls == CLS_STORE) r_state <= FETCH;
            else                    r_state <= WB;
          end
        end
        WB:      r_state <= FETCH;
        TRAP:    r_state <= FETCH;
        HALT:    r_state <= HALT;
        default: r_state <= FETCH;
      endcase
    end
  end

  // Outputs decode from the state register; the only input-dependent terms are the
  // fetch ack (IR load), the branch outcome and the store-completion ack.
  always_comb begin
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    ir_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    pc_sel_o   = PC_PLUS4;
    rf_we_o    = 1'b0;
    wb_sel_o   = WB_ALU;
    retire_o   = 1'b0;
    trap_o     = 1'b0;
    halt_o     = 1'b0;
    if (!rst) begin
      case (r_state)
        FETCH: begin
          imem_req_o = 1'b1;
          ir_we_o    = imem_ack_i;
        end
        EXECUTE: begin
          if (r_cls == CLS_BRANCH) begin
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
            pc_sel_o = br_taken_i ? PC_TARGET : PC_PLUS4;
          end
        end
        MEM: begin
          dmem_req_o = 1'b1;
          dmem_we_o  = (r_cls == CLS_STORE);
          if (dmem_ack_i && (r_cls == CLS_STORE)) begin
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
          end
        end
        WB: begin
          rf_we_o  = 1'b1;
          pc_we_o  = 1'b1;
          retire_o = 1'b1;
          case (r_cls)
            CLS_LOAD: wb_sel_o = WB_MEM;
            CLS_JAL:  begin wb_sel_o = WB_PC4; pc_sel_o = PC_TARGET; end
            CLS_JALR: begin wb_sel_o = WB_PC4; pc_sel_o = PC_JALR;   end
            CLS_LUI:  wb_sel_o = WB_IMM;
            default:  wb_sel_o = WB_ALU;
          endcase
        end
        TRAP: begin
          trap_o   = 1'b1;
          pc_we_o  = 1'b1;
          pc_sel_o = PC_TRAP;
        end
        HALT:    halt_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign alu_op_o = r_aluOp;

`ifdef RISCV_SEQ_PERF_CNT_EN
  logic [31:0] r_cycleCnt;
  logic [31:0] r_instretCnt;

  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycleCnt   <= '0;
      r_instretCnt <= '0;
    end else begin
      r_cycleCnt <= r_cycleCnt + 32'd1;
      if (retire_o) r_instretCnt <= r_instretCnt + 32'd1;
    end
  end

  assign cycle_cnt_o   = r_cycleCnt;
  assign instret_cnt_o = r_instretCnt;
`endif

endmodule

// File: tb/tb_risc_v_mc_sequencer.sv
// Bench for risc_v_mc_sequencer: directed instructions, expected retire/trap/halt events
// queued per instruction and checked by an independent monitor.
`timescale 1ns/1ps
module tb_risc_v_mc_sequencer;
  import risc_v_mike_pkg::*;

  typedef struct {
    int              kind;
    t_pc_sel         pcSel;
    logic            rfWe;
    t_wb_sel         wbSel;
    t_instr_nmemonic op;
    int              lat;
    int              dmemCyc;
    logic            dmemWe;
  } t_exp;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     instr_i = 32'h0;
  logic            imem_ack_i = 1'b0;
  logic            dmem_ack_i = 1'b0;
  logic            br_taken_i = 1'b0;
  logic            imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o;
  logic            rf_we_o, retire_o, trap_o, halt_o;
  t_pc_sel         pc_sel_o;
  t_wb_sel         wb_sel_o;
  t_instr_nmemonic alu_op_o;
`ifdef RISCV_SEQ_PERF_CNT_EN
  logic [31:0]     cycle_cnt_o, instret_cnt_o;
`endif

  int   compared = 0;
  int   mismatched = 0;
  int   doneCnt = 0;
  int   imemWait = 0;
  int   dmemWait = 0;
  logic spurious = 1'b0;
  t_exp expQ[$];

  risc_v_mc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .instr_i       (instr_i),
    .imem_req_o    (imem_req_o),
    .imem_ack_i    (imem_ack_i),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_ack_i    (dmem_ack_i),
    .br_taken_i    (br_taken_i),
    .ir_we_o       (ir_we_o),
    .pc_we_o       (pc_we_o),
    .pc_sel_o      (pc_sel_o),
    .rf_we_o       (rf_we_o),
    .wb_sel_o      (wb_sel_o),
    .alu_op_o      (alu_op_o),
    .retire_o      (retire_o),
    .trap_o        (trap_o),
    .halt_o        (halt_o)
`ifdef RISCV_SEQ_PERF_CNT_EN
    ,
    .cycle_cnt_o   (cycle_cnt_o),
    .instret_cnt_o (instret_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic t_exp mkExp(input int kind, input t_pc_sel pcSel, input logic rfWe,
                                 input t_wb_sel wbSel, input t_instr_nmemonic op,
                                 input int lat, input int dmemCyc, input logic dmemWe);
    t_exp e;
    e.kind = kind; e.pcSel = pcSel; e.rfWe = rfWe; e.wbSel = wbSel;
    e.op = op; e.lat = lat; e.dmemCyc = dmemCyc; e.dmemWe = dmemWe;
    return e;
  endfunction

  // Memory responder: acks after the programmed number of wait cycles; optionally
  // drives a stray dmem ack whenever no data request is pending.
  initial begin
    int iCnt;
    int dCnt;
    iCnt = 0;
    dCnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        imem_ack_i = 1'b0; dmem_ack_i = 1'b0; iCnt = 0; dCnt = 0;
      end else begin
        if (imem_req_o) begin
          if (iCnt >= imemWait) imem_ack_i = 1'b1;
          else begin imem_ack_i = 1'b0; iCnt++; end
        end else begin
          imem_ack_i = 1'b0; iCnt = 0;
        end
        if (dmem_req_o) begin
          if (dCnt >= dmemWait) dmem_ack_i = 1'b1;
          else begin dmem_ack_i = 1'b0; dCnt++; end
        end else begin
          dmem_ack_i = spurious; dCnt = 0;
        end
      end
    end
  end

  // Monitor: accumulates per-instruction activity and checks each event against the queue.
  initial begin
    int   cyc, startCyc, dmemCyc, rfWeCyc, irWeCnt, kind;
    logic inInstr, dmemWeSeen, prevHalt;
    t_exp e;
    cyc = 0; startCyc = 0; dmemCyc = 0; rfWeCyc = 0; irWeCnt = 0; kind = 0;
    inInstr = 1'b0; dmemWeSeen = 1'b0; prevHalt = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (rst) begin
        inInstr = 1'b0;
        prevHalt = 1'b0;
      end else begin
        if (imem_req_o && !inInstr) begin
          inInstr = 1'b1; startCyc = cyc;
          dmemCyc = 0; rfWeCyc = 0; irWeCnt = 0; dmemWeSeen = 1'b0;
        end
        if (dmem_req_o) begin
          dmemCyc++;
          if (dmem_we_o) dmemWeSeen = 1'b1;
        end
        if (rf_we_o) rfWeCyc++;
        if (ir_we_o) irWeCnt++;
        if (retire_o || trap_o || (halt_o && !prevHalt)) begin
          kind = retire_o ? 0 : (trap_o ? 1 : 2);
          if (expQ.size() == 0) begin
            checkOutput("unexpected_event", kind, -1);
          end else begin
            e = expQ.pop_front();
            checkOutput("event_kind", kind, e.kind);
            checkOutput("latency", cyc - startCyc + 1, e.lat);
            checkOutput("alu_op", int'(alu_op_o), int'(e.op));
            checkOutput("ir_we_pulses", irWeCnt, 1);
            checkOutput("pc_we", int'(pc_we_o), (e.kind == 2) ? 0 : 1);
            if (e.kind != 2) checkOutput("pc_sel", int'(pc_sel_o), int'(e.pcSel));
            checkOutput("rf_we_cycles", rfWeCyc, e.rfWe ? 1 : 0);
            if (e.rfWe) checkOutput("wb_sel", int'(wb_sel_o), int'(e.wbSel));
            checkOutput("dmem_req_cycles", dmemCyc, e.dmemCyc);
            if (e.dmemCyc > 0) checkOutput("dmem_we", int'(dmemWeSeen), int'(e.dmemWe));
            if (e.kind == 1) checkOutput("trap_no_retire", int'(retire_o), 0);
          end
          inInstr = 1'b0;
          doneCnt++;
        end
        prevHalt = halt_o;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] instr, input logic taken, input int iW,
                               input int dW, input logic spur, input t_exp e);
    int d0;
    int n;
    instr_i = instr; br_taken_i = taken; imemWait = iW; dmemWait = dW; spurious = spur;
    expQ.push_back(e);
    d0 = doneCnt;
    n = 0;
    while ((doneCnt == d0) && (n < 80)) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (doneCnt == d0) begin
      checkOutput("event_timeout", 0, 1);
      expQ.delete();
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic checkHalted(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_halt_held"}, int'(halt_o), 1);
      checkOutput({tag, "_halt_no_fetch"}, int'(imem_req_o), 0);
    end
  endtask

  initial begin
    int n;
`ifdef RISCV_SEQ_PERF_CNT_EN
    logic [31:0] c0, r0;
`endif
    @(negedge clk);
    #2;
    checkOutput("rst_imem_req", int'(imem_req_o), 0);
    checkOutput("rst_pc_we", int'(pc_we_o), 0);
    checkOutput("rst_retire", int'(retire_o), 0);
    checkOutput("rst_halt", int'(halt_o), 0);
    checkOutput("rst_alu_op", int'(alu_op_o), int'(OP_NA));
`ifdef RISCV_SEQ_PERF_CNT_EN
    checkOutput("rst_cycle_cnt", int'(cycle_cnt_o), 0);
    checkOutput("rst_instret_cnt", int'(instret_cnt_o), 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(32'h002081B3, 1'b0, 0, 0, 1'b0, mkExp(0, PC_PLUS4, 1'b1, WB_ALU, OP_ADD, 4, 0, 1'b0));
    applyStimulus(32'h402081B3, 1'b0, 2, 0, 1'b0, mkExp(0, PC_PLUS4, 1'b1, WB_ALU, OP_SUB, 6, 0, 1'b0));
    applyStimulus(32'h0000A283, 1'b0, 0, 3, 1'b0, mkExp(0, PC_PLUS4, 1'b1, WB_MEM, OP_LW, 8, 4, 1'b0));
    applyStimulus(32'h0050A023, 1'b0, 0, 0, 1'b0, mkExp(0, PC_PLUS4, 1'b0, WB_ALU, OP_SW, 4, 1, 1'b1));
    applyStimulus(32'h0050A023, 1'b0, 0, 2, 1'b0, mkExp(0, PC_PLUS4, 1'b0, WB_ALU, OP_SW, 6, 3, 1'b1));
    applyStimulus(32'h00208463, 1'b1, 0, 0, 1'b0, mkExp(0, PC_TARGET, 1'b0, WB_ALU, OP_BEQ, 3, 0, 1'b0));
    applyStimulus(32'h00208463, 1'b0, 0, 0, 1'b0, mkExp(0, PC_PLUS4, 1'b0, WB_ALU, OP_BEQ, 3, 0, 1'b0));
    applyStimulus(32'h00209463, 1'b1, 0, 0, 1'b1, mkExp(0, PC_TARGET, 1'b0, WB_ALU, OP_BNE, 3, 0, 1'b0));
    applyStimulus(32'h0000A283, 1'b0, 0, 2, 1'b1, mkExp(0, PC_PLUS4, 1'b1, WB_MEM, OP_LW, 7, 3, 1'b0));
    applyStimulus(32'h000000EF, 1'b0, 0, 0, 1'b0, mkExp(0, PC_TARGET, 1'b1, WB_PC4, OP_JAL, 4, 0, 1'b0));
    applyStimulus(32'h00008067, 1'b0, 0, 0, 1'b0, mkExp(0, PC_JALR, 1'b1, WB_PC4, OP_JALR, 4, 0, 1'b0));
    applyStimulus(32'h123452B7, 1'b0, 0, 0, 1'b0, mkExp(0, PC_PLUS4, 1'b1, WB_IMM, OP_LUI, 4, 0, 1'b0));
    applyStimulus(32'h00000097, 1'b0, 0, 0, 1'b0, mkExp(0, PC_PLUS4, 1'b1, WB_ALU, OP_AUIPC, 4, 0, 1'b0));
    applyStimulus(32'h00000013, 1'b0, 0, 0, 1'b0, mkExp(0, PC_PLUS4, 1'b1, WB_ALU, OP_ADDI, 4, 0, 1'b0));
    applyStimulus(32'h00000073, 1'b0, 0, 0, 1'b0, mkExp(1, PC_TRAP, 1'b0, WB_ALU, OP_ECALL, 3, 0, 1'b0));
    applyStimulus(32'h002081B3, 1'b0, 0, 0, 1'b0, mkExp(0, PC_PLUS4, 1'b1, WB_ALU, OP_ADD, 4, 0, 1'b0));

`ifdef RISCV_SEQ_PERF_CNT_EN
    c0 = cycle_cnt_o;
    r0 = instret_cnt_o;
    for (int i = 0; i < 10; i++)
      applyStimulus(32'h002081B3, 1'b0, 0, 0, 1'b0, mkExp(0, PC_PLUS4, 1'b1, WB_ALU, OP_ADD, 4, 0, 1'b0));
    checkOutput("cycle_cnt_delta", int'(cycle_cnt_o - c0), 40);
    checkOutput("instret_cnt_delta", int'(instret_cnt_o - r0), 10);
`endif

    // Reset in the middle of a long data access.
    instr_i = 32'h0000A283; br_taken_i = 1'b0; imemWait = 0; dmemWait = 40; spurious = 1'b0;
    n = 0;
    while (!dmem_req_o && (n < 20)) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("mem_reached", int'(dmem_req_o), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_drops_dmem_req", int'(dmem_req_o), 0);
    checkOutput("rst_no_retire", int'(retire_o), 0);
    @(posedge clk);
    @(posedge clk);
    #1 dmemWait = 0;
    rst = 1'b0;
    #1;
    checkOutput("post_rst_imem_req", int'(imem_req_o), 1);
    checkOutput("post_rst_alu_op", int'(alu_op_o), int'(OP_NA));
    applyStimulus(32'h0000A283, 1'b0, 0, 0, 1'b0, mkExp(0, PC_PLUS4, 1'b1, WB_MEM, OP_LW, 5, 1, 1'b0));

    applyStimulus(32'h00100073, 1'b0, 0, 0, 1'b0, mkExp(2, PC_PLUS4, 1'b0, WB_ALU, OP_EBREAK, 3, 0, 1'b0));
    checkHalted("ebreak");
    applyReset();
    applyStimulus(32'hFFFFFFFF, 1'b0, 0, 0, 1'b0, mkExp(2, PC_PLUS4, 1'b0, WB_ALU, OP_NA, 3, 0, 1'b0));
    checkHalted("illegal");
    applyReset();
    applyStimulus(32'h002081B3, 1'b0, 0, 0, 1'b0, mkExp(0, PC_PLUS4, 1'b1, WB_ALU, OP_ADD, 4, 0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
